// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator; one SCLK half-period every CLK_DIV cycles, registered pins, tx_ready only in IDLE/WAIT.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first in both directions (default MSB first).
module spi_master_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic       SPI_CLK,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCLK,
  output logic       SCSN,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      sh_tx, sh_tx_d;
  logic [7:0]      sh_rx, sh_rx_d;
  logic            last_q, last_d;
  logic            sclk_d, scsn_d, mosi_d;
  logic [7:0]      rx_data_d;
  logic            rx_valid_d;
  logic            accept;
  logic [7:0]      rx_shift, tx_shift;
  logic            first_bit, next_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign rx_shift  = {MISO, sh_rx[7:1]};
  assign tx_shift  = {1'b0, sh_tx[7:1]};
  assign first_bit = tx_data[0];
  assign next_bit  = tx_shift[0];
`else
  assign rx_shift  = {sh_rx[6:0], MISO};
  assign tx_shift  = {sh_tx[6:0], 1'b0};
  assign first_bit = tx_data[7];
  assign next_bit  = tx_shift[7];
`endif

  assign tx_ready = (state == IDLE) || (state == WAIT);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d    = state;
    cnt_d      = (cnt != '0) ? cnt - 1'b1 : cnt;
    bit_cnt_d  = bit_cnt;
    sh_tx_d    = sh_tx;
    sh_rx_d    = sh_rx;
    last_d     = last_q;
    sclk_d     = SCLK;
    scsn_d     = SCSN;
    mosi_d     = MOSI;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_tx_d = tx_data;
          last_d  = tx_last;
          scsn_d  = 1'b0;
          mosi_d  = first_bit;
          cnt_d   = CW'(CS_SETUP - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          cnt_d   = CW'(CLK_DIV - 1);
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          sclk_d  = 1'b1;
          cnt_d   = CW'(CLK_DIV - 1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        // MISO is sampled at the very end of the high phase, just before the fall
        if (cnt == '0) begin
          sh_rx_d = rx_shift;
          sclk_d  = 1'b0;
          if (bit_cnt != 3'd7) begin
            bit_cnt_d = bit_cnt + 3'd1;
            sh_tx_d   = tx_shift;
            mosi_d    = next_bit;
            cnt_d     = CW'(CLK_DIV - 1);
            state_d   = LOW;
          end else begin
            bit_cnt_d  = 3'd0;
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
            if (last_q) begin
              cnt_d   = CW'(CS_HOLD - 1);
              state_d = HOLD;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (accept) begin
          sh_tx_d = tx_data;
          last_d  = tx_last;
          mosi_d  = first_bit;
          cnt_d   = CW'(CLK_DIV - 1);
          state_d = LOW;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          scsn_d  = 1'b1;
          cnt_d   = CW'(CS_IDLE - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SPI_CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= 3'd0;
      sh_tx    <= 8'h00;
      sh_rx    <= 8'h00;
      last_q   <= 1'b0;
      SCLK     <= 1'b0;
      SCSN     <= 1'b1;
      MOSI     <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_cnt  <= bit_cnt_d;
      sh_tx    <= sh_tx_d;
      sh_rx    <= sh_rx_d;
      last_q   <= last_d;
      SCLK     <= sclk_d;
      SCSN     <= scsn_d;
      MOSI     <= mosi_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
    end
  end

endmodule
